// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply
// and restoring unsigned divide/remainder, with valid/ready on both sides.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [SHW-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = y[SHW-1:0];
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      4'b1000: r = x >> sh;
      4'b1001: r = x << sh;
      4'b1010: r = $signed(x) >>> sh;
      4'b1101: r = x ^ y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One multiply step: add the shifted multiplicand when the current multiplier bit is set
  logic [WIDTH-1:0] mul_acc;
  // One restoring-division step: acc_q is the partial remainder, a_q shifts dividend out and quotient in
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx, quo_nx, step_res;
  logic [WIDTH-1:0] single_res;

  always_comb begin
    mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    rem_sh   = {acc_q, a_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_sub  = rem_sh - {1'b0, b_q};
    rem_nx   = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx   = {a_q[WIDTH-2:0], rem_ge};
    case (kind_q)
      K_MUL:   step_res = mul_acc;
      K_DIV:   step_res = quo_nx;
      default: step_res = rem_nx;
    endcase
    single_res = single_op(alu_op, op1, op2);
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (alu_op == 4'b0011 || alu_op == 4'b0100 || alu_op == 4'b0101) begin
              a_d     = op1;
              b_d     = op2;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH - 1);
              kind_d  = (alu_op == 4'b0011) ? K_MUL :
                        (alu_op == 4'b0100) ? K_DIV : K_REM;
              state_d = BUSY;
            end else begin
              result_d = single_res;
              zero_d   = (single_res == '0);
              state_d  = DONE;
            end
          end
        end
        BUSY: begin
          if (kind_q == K_MUL) begin
            acc_d = mul_acc;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else begin
            acc_d = rem_nx;
            a_d   = quo_nx;
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            result_d = step_res;
            zero_d   = (step_res == '0);
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kind_q   <= K_MUL;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (WIDTH 8/32/64) share stimulus and are
// compared against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [3:0]  alu_op;
  logic [63:0] op1, op2;

  logic ir8, v8, z8, ir32, v32, z32, ir64, v64, z64;
  logic [7:0]  r8;
  logic [31:0] r32;
  logic [63:0] r64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .alu_op(alu_op),
    .op1(op1[7:0]), .op2(op2[7:0]), .flush(flush), .out_valid(v8), .out_ready(out_ready),
    .result(r8), .zero(z8));

  alu_seq #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .alu_op(alu_op),
    .op1(op1[31:0]), .op2(op2[31:0]), .flush(flush), .out_valid(v32), .out_ready(out_ready),
    .result(r32), .zero(z32));

  alu_seq #(.WIDTH(64)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .alu_op(alu_op),
    .op1(op1), .op2(op2), .flush(flush), .out_valid(v64), .out_ready(out_ready),
    .result(r64), .zero(z64));

  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input int w);
    logic [63:0] mask, a, b, sa, sb, r;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a  = a_in & mask;
    b  = b_in & mask;
    sh = int'(b % 64'(w));
    sa = a[w-1] ? (a | ~mask) : a;
    sb = b[w-1] ? (b | ~mask) : b;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a * b;
      4'b0100: r = (b == 0) ? mask : a / b;
      4'b0101: r = (b == 0) ? a : a % b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      4'b1000: r = a >> sh;
      4'b1001: r = a << sh;
      4'b1010: r = $signed(sa) >>> sh;
      4'b1101: r = a ^ b;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int lat[3];
    int wd[3];
    logic [63:0] got[3];
    logic gz[3];
    logic [63:0] exp_r;
    bit iter, bad_rdy;
    wd  = '{8, 32, 64};
    lat = '{-1, -1, -1};
    bad_rdy = 0;
    iter = (op == 4'b0011 || op == 4'b0100 || op == 4'b0101);
    alu_op = op; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 4'($urandom); op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
    for (int j = 0; j <= 150; j++) begin
      if (v8  && lat[0] < 0) lat[0] = j;
      if (v32 && lat[1] < 0) lat[1] = j;
      if (v64 && lat[2] < 0) lat[2] = j;
      if (!v32 && ir32) bad_rdy = 1;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(posedge clk); #1;
    end
    got = '{{56'd0, r8}, {32'd0, r32}, r64};
    gz  = '{z8, z32, z64};
    for (int i = 0; i < 3; i++) begin
      exp_r = model(op, a, b, wd[i]);
      n_cmp++;
      if (lat[i] !== (iter ? wd[i] : 0)) begin
        n_err++;
        $display("FAIL latency w=%0d op=%b got=%0d exp=%0d", wd[i], op, lat[i], iter ? wd[i] : 0);
      end
      n_cmp++;
      if (got[i] !== exp_r) begin
        n_err++;
        $display("FAIL result w=%0d op=%b a=%h b=%h got=%h exp=%h", wd[i], op, a, b, got[i], exp_r);
      end
      n_cmp++;
      if (gz[i] !== (exp_r == 64'd0)) begin
        n_err++;
        $display("FAIL zero w=%0d op=%b got=%b exp=%b", wd[i], op, gz[i], exp_r == 64'd0);
      end
    end
    n_cmp++;
    if (bad_rdy) begin
      n_err++;
      $display("FAIL busy_in_ready op=%b got=1 exp=0", op);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (v32 !== 1'b0 || ir32 !== 1'b1) begin
      n_err++;
      $display("FAIL handshake_idle got v=%b rdy=%b exp v=0 rdy=1", v32, ir32);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ir32 !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready_held got=%b exp=1", ir32);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ir32 !== 1'b1 || v32 !== 1'b0 || r32 !== 32'd0 || z32 !== 1'b0 || v8 !== 1'b0 || v64 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got rdy=%b v=%b r=%h z=%b exp rdy=1 v=0 r=0 z=0", ir32, v32, r32, z32);
    end
  endtask

  task automatic test_single();
    run_op(4'b0110, 64'd5, 64'd5);
    n_cmp++;
    if (r32 !== 32'd0 || z32 !== 1'b1) begin
      n_err++; $display("FAIL sub_zero got r=%h z=%b exp r=0 z=1", r32, z32);
    end
    run_op(4'b0111, 64'hFFFF_FFFF, 64'd1);
    n_cmp++;
    if (r32 !== 32'd1) begin
      n_err++; $display("FAIL slt_signed got=%h exp=1", r32);
    end
    run_op(4'b1010, 64'h8000_0000, 64'd4);
    n_cmp++;
    if (r32 !== 32'hF800_0000) begin
      n_err++; $display("FAIL sra got=%h exp=f8000000", r32);
    end
    run_op(4'b1000, 64'hF000_0000, 64'h24);
    n_cmp++;
    if (r32 !== 32'h0F00_0000) begin
      n_err++; $display("FAIL srl_shamt got=%h exp=0f000000", r32);
    end
    run_op(4'b1111, 64'd5, 64'd3);
    n_cmp++;
    if (r32 !== 32'd0 || z32 !== 1'b1) begin
      n_err++; $display("FAIL unused_op got r=%h z=%b exp r=0 z=1", r32, z32);
    end
  endtask

  task automatic test_iterative();
    run_op(4'b0011, 64'hFFFF_FFFF, 64'd3);
    n_cmp++;
    if (r32 !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL mul got=%h exp=fffffffd", r32);
    end
    run_op(4'b0100, 64'd100, 64'd7);
    n_cmp++;
    if (r32 !== 32'd14) begin
      n_err++; $display("FAIL divu got=%0d exp=14", r32);
    end
    run_op(4'b0101, 64'd100, 64'd7);
    n_cmp++;
    if (r32 !== 32'd2) begin
      n_err++; $display("FAIL remu got=%0d exp=2", r32);
    end
    run_op(4'b0100, 64'h1234_5678, 64'd0);
    n_cmp++;
    if (r32 !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL divu_by0 got=%h exp=ffffffff", r32);
    end
    run_op(4'b0101, 64'd9, 64'd0);
    n_cmp++;
    if (r32 !== 32'd9) begin
      n_err++; $display("FAIL remu_by0 got=%0d exp=9", r32);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] held_r;
    logic        held_z;
    bit          seen, bad;
    alu_op = 4'b0011; op1 = 64'd1234567; op2 = 64'd89; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 4'b0010; op1 = 64'd40; op2 = 64'd2;
    seen = 0;
    for (int j = 0; j < 150; j++) begin
      if (v64 && v32 && v8) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!seen || r32 !== model(4'b0011, 64'd1234567, 64'd89, 32)) begin
      n_err++; $display("FAIL bp_mul got=%h done=%b exp=%h", r32, seen, model(4'b0011, 64'd1234567, 64'd89, 32));
    end
    held_r = r32; held_z = z32; bad = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (r32 !== held_r || z32 !== held_z || v32 !== 1'b1 || ir32 !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL bp_hold got r=%h v=%b rdy=%b exp r=%h v=1 rdy=0", r32, v32, ir32, held_r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (ir32 !== 1'b1 || v32 !== 1'b0) begin
      n_err++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", ir32, v32);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (v32 !== 1'b1 || r32 !== 32'd42) begin
      n_err++; $display("FAIL bp_pending_accept got v=%b r=%0d exp v=1 r=42", v32, r32);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] held_r;
    bit bad;
    alu_op = 4'b0100; op1 = 64'd1000; op2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (ir32 !== 1'b1 || v32 !== 1'b0) begin
      n_err++; $display("FAIL flush_busy got rdy=%b v=%b exp rdy=1 v=0", ir32, v32);
    end
    bad = 0;
    for (int j = 0; j < 70; j++) begin
      @(posedge clk); #1;
      if (v8 || v32 || v64) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL flush_no_result got=1 exp=0");
    end
    alu_op = 4'b0010; op1 = 64'd7; op2 = 64'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    held_r = r32;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (v32 !== 1'b0 || r32 !== 32'd15 || held_r !== 32'd15) begin
      n_err++; $display("FAIL flush_done got v=%b r=%0d exp v=0 r=15", v32, r32);
    end
    alu_op = 4'b1101; op1 = 64'hFF; op2 = 64'h0F; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (v32 !== 1'b0 || ir32 !== 1'b1 || r32 !== 32'd15) begin
      n_err++; $display("FAIL flush_vs_accept got v=%b rdy=%b r=%0d exp v=0 rdy=1 r=15", v32, ir32, r32);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (v32 !== 1'b0) begin
      n_err++; $display("FAIL flush_vs_accept_late got v=%b exp v=0", v32);
    end
  endtask

  task automatic test_reset_mid_busy();
    alu_op = 4'b0011; op1 = 64'd77; op2 = 64'd55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (v32 !== 1'b0 || ir32 !== 1'b1 || r32 !== 32'd0 || z32 !== 1'b0) begin
      n_err++; $display("FAIL async_reset got v=%b rdy=%b r=%h z=%b exp v=0 rdy=1 r=0 z=0", v32, ir32, r32, z32);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] ops[13];
    logic [3:0] op;
    logic [63:0] a, b;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
            4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1011};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 12)];
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom};
      endcase
      run_op(op, a, b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_iterative();
    test_back_pressure();
    test_flush();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
